// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
// Writeback controller for the single register-file write port.
//
// Two requesters (ALU and LSU) compete for one registered write
// (wr_en/addr_rd/data_rd). A per-register pending-write scoreboard is set
// when an instruction issues and cleared when its writeback is driven.
// Decode uses this scoreboard to stall on RAW hazards.
//
// Configuration macro:
//   WB_RR_ARB_EN  defined   -> round-robin arbitration with a 1-bit pointer
//                 undefined -> fixed priority, LSU wins over ALU
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   iss_valid, iss_rd       issued instruction marks iss_rd pending
//   addr_rs1, addr_rs2      hazard query addresses
//   rs1_busy, rs2_busy      pending-write status of the queried registers
//   alu_valid/rd/data       ALU writeback request
//   alu_ready               ALU request accepted this cycle
//   lsu_valid/rd/data       LSU writeback request
//   lsu_ready               LSU request accepted this cycle
//   wr_en, addr_rd, data_rd registered register-file write
//   sb_empty                registered flag, no pending writes
// -----------------------------------------------------------------------------
module reg_wb_ctrl #(
   parameter int NUM_REG        = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      iss_valid,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
   input  logic [REG_ADDR_WIDTH-1:0] addr_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] addr_rs2,
   output logic                      rs1_busy,
   output logic                      rs2_busy,
   input  logic                      alu_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [REG_WIDTH-1:0]      alu_data,
   output logic                      alu_ready,
   input  logic                      lsu_valid,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
   input  logic [REG_WIDTH-1:0]      lsu_data,
   output logic                      lsu_ready,
   output logic                      wr_en,
   output logic [REG_ADDR_WIDTH-1:0] addr_rd,
   output logic [REG_WIDTH-1:0]      data_rd,
   output logic                      sb_empty
);

   logic [NUM_REG-1:0]        busy;
   logic [NUM_REG-1:0]        busy_next;
   logic                      accept;
   logic [REG_ADDR_WIDTH-1:0] sel_rd;
   logic [REG_WIDTH-1:0]      sel_data;

`ifdef WB_RR_ARB_EN
   typedef enum logic {
      PREF_ALU = 1'b0,
      PREF_LSU = 1'b1
   } pref_t;

   pref_t pref;

   // Round-robin grant: the preferred requester wins a tie, a lone
   // requester is always granted so the port never idles.
   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (alu_valid && lsu_valid) begin
         if (pref == PREF_LSU) begin
            lsu_ready = 1'b1;
         end else begin
            alu_ready = 1'b1;
         end
      end else begin
         alu_ready = alu_valid;
         lsu_ready = lsu_valid;
      end
   end

   // After any grant, preference moves to the requester that lost
   // (or was absent), including lone grants.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pref <= PREF_ALU;
      end else if (alu_ready) begin
         pref <= PREF_LSU;
      end else if (lsu_ready) begin
         pref <= PREF_ALU;
      end
   end
`else
   // Fixed priority: a load result always beats an ALU result.
   always_comb begin
      lsu_ready = lsu_valid;
      alu_ready = alu_valid & ~lsu_valid;
   end
`endif

   // Select the winning request; the arbiter guarantees one-hot readies.
   always_comb begin
      accept   = alu_ready | lsu_ready;
      sel_rd   = lsu_ready ? lsu_rd   : alu_rd;
      sel_data = lsu_ready ? lsu_data : alu_data;
   end

   // Registered write port. A write to x0 is accepted but never drives
   // wr_en; address and data hold their last value when nothing is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         addr_rd <= '0;
         data_rd <= '0;
      end else begin
         wr_en <= accept && (sel_rd != '0);
         if (accept) begin
            addr_rd <= sel_rd;
            data_rd <= sel_data;
         end
      end
   end

   // Scoreboard update. The clear is applied first so that an issue to the
   // same register in the same cycle leaves the bit set: a newer producer
   // is still in flight. Bit 0 is forced low because x0 is never written.
   always_comb begin
      busy_next = busy;
      if (wr_en) begin
         busy_next[addr_rd] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
         busy_next[iss_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // sb_empty looks at the post-edge scoreboard so it is valid in the same
   // cycle the last bit clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= '0;
         sb_empty <= 1'b1;
      end else begin
         busy     <= busy_next;
         sb_empty <= (busy_next == '0);
      end
   end

   // Hazard queries read the registered bits directly, with no bypass from
   // the write in flight. Addresses beyond NUM_REG read as not busy.
   always_comb begin
      rs1_busy = (int'(addr_rs1) < NUM_REG) ? busy[addr_rs1] : 1'b0;
      rs2_busy = (int'(addr_rs2) < NUM_REG) ? busy[addr_rs2] : 1'b0;
   end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_ctrl
// Self-checking bench for reg_wb_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model that keeps the
// scoreboard as an array of bits and the write port as plain variables.
// -----------------------------------------------------------------------------
module tb_reg_wb_ctrl;

   localparam int NUM_REG = 32;
   localparam int AW      = 5;
   localparam int DW      = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic [AW-1:0] addr_rs1;
   logic [AW-1:0] addr_rs2;
   logic          rs1_busy;
   logic          rs2_busy;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          lsu_valid;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;
   logic          wr_en;
   logic [AW-1:0] addr_rd;
   logic [DW-1:0] data_rd;
   logic          sb_empty;

   reg_wb_ctrl #(
      .NUM_REG       (NUM_REG),
      .REG_ADDR_WIDTH(AW),
      .REG_WIDTH     (DW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .addr_rs1 (addr_rs1),
      .addr_rs2 (addr_rs2),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .alu_valid(alu_valid),
      .alu_rd   (alu_rd),
      .alu_data (alu_data),
      .alu_ready(alu_ready),
      .lsu_valid(lsu_valid),
      .lsu_rd   (lsu_rd),
      .lsu_data (lsu_data),
      .lsu_ready(lsu_ready),
      .wr_en    (wr_en),
      .addr_rd  (addr_rd),
      .data_rd  (data_rd),
      .sb_empty (sb_empty)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   // Reference model state
   bit            modelBusy [NUM_REG];
   bit            modelWrEn;
   logic [AW-1:0] modelAddr;
   logic [DW-1:0] modelData;
   bit            modelPrefLsu;
   bit            expAluGnt;
   bit            expLsuGnt;

   // Held requester state used by multi-cycle scenarios and the random run
   bit            aV;
   logic [AW-1:0] aR;
   logic [DW-1:0] aD;
   bit            lV;
   logic [AW-1:0] lR;
   logic [DW-1:0] lD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void modelReset();
      foreach (modelBusy[i]) modelBusy[i] = 1'b0;
      modelWrEn    = 1'b0;
      modelAddr    = '0;
      modelData    = '0;
      modelPrefLsu = 1'b0;
   endfunction

   // Who should be granted given the inputs currently driven
   function automatic void computeGrant();
      expAluGnt = 1'b0;
      expLsuGnt = 1'b0;
      if (alu_valid && lsu_valid) begin
`ifdef WB_RR_ARB_EN
         if (modelPrefLsu) expLsuGnt = 1'b1;
         else              expAluGnt = 1'b1;
`else
         expLsuGnt = 1'b1;
`endif
      end else begin
         expAluGnt = alu_valid;
         expLsuGnt = lsu_valid;
      end
   endfunction

   function automatic bit modelEmpty();
      foreach (modelBusy[i]) if (modelBusy[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic applyStimulus(input bit iv, input logic [AW-1:0] ir,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                                input bit lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
      iss_valid = iv;
      iss_rd    = ir;
      addr_rs1  = r1;
      addr_rs2  = r2;
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = ad;
      lsu_valid = lv;
      lsu_rd    = lr;
      lsu_data  = ld;
      #1;
   endtask

   // Combinational outputs versus the model for the inputs now applied
   task automatic checkOutput();
      computeGrant();
      check("alu_ready", alu_ready, expAluGnt);
      check("lsu_ready", lsu_ready, expLsuGnt);
      check("rs1_busy", rs1_busy, modelBusy[addr_rs1]);
      check("rs2_busy", rs2_busy, modelBusy[addr_rs2]);
   endtask

   // Advance the model and the DUT by one edge, then compare registered outputs
   task automatic clockStep();
      bit            nb [NUM_REG];
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      computeGrant();
      nb = modelBusy;
      if (modelWrEn) nb[modelAddr] = 1'b0;
      if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (expAluGnt || expLsuGnt) begin
         rd        = expLsuGnt ? lsu_rd : alu_rd;
         data      = expLsuGnt ? lsu_data : alu_data;
         modelWrEn = (rd != 0);
         modelAddr = rd;
         modelData = data;
      end else begin
         modelWrEn = 1'b0;
      end
      if (expAluGnt)      modelPrefLsu = 1'b1;
      else if (expLsuGnt) modelPrefLsu = 1'b0;
      modelBusy = nb;
      @(posedge clk);
      #1;
      check("wr_en", wr_en, modelWrEn);
      if (modelWrEn) begin
         check("addr_rd", addr_rd, modelAddr);
         check("data_rd", data_rd, modelData);
      end
      check("sb_empty", sb_empty, modelEmpty());
   endtask

   task automatic idleStep(input logic [AW-1:0] r1);
      applyStimulus(0, 0, r1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      clockStep();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired before the bench finished");
      $fatal(1);
   end

   initial begin
      bit expAlu;

      // ---------------- Reset state ----------------
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      modelReset();
      #10;
      check("reset_wr_en", wr_en, 0);
      check("reset_addr_rd", addr_rd, 0);
      check("reset_data_rd", data_rd, 0);
      check("reset_sb_empty", sb_empty, 1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- Single ALU writeback ----------------
      applyStimulus(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      clockStep();
      applyStimulus(0, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      checkOutput();
      check("single_rs1_busy", rs1_busy, 1);
      check("single_alu_ready", alu_ready, 1);
      clockStep();
      check("single_wr_en", wr_en, 1);
      check("single_addr", addr_rd, 5);
      check("single_data", data_rd, 32'hDEADBEEF);
      applyStimulus(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      check("single_nobypass", rs1_busy, 1);
      clockStep();
      check("single_sb_empty", sb_empty, 1);
      applyStimulus(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      check("single_rs1_clear", rs1_busy, 0);
      clockStep();

      // ---------------- Contention ----------------
      // Preference is with LSU here in both builds (ALU won last).
      applyStimulus(0, 0, 0, 0, 1, 3, 32'h11, 1, 4, 32'h22);
      checkOutput();
      check("contend_lsu_first", lsu_ready, 1);
      check("contend_alu_wait", alu_ready, 0);
      clockStep();
      check("contend_addr1", addr_rd, 4);
      check("contend_data1", data_rd, 32'h22);
      applyStimulus(0, 0, 0, 0, 1, 3, 32'h11, 0, 0, 0);
      checkOutput();
      check("contend_alu_second", alu_ready, 1);
      clockStep();
      check("contend_addr2", addr_rd, 3);
      check("contend_data2", data_rd, 32'h11);

      // Lone LSU grant hands preference back to ALU in the round-robin build
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66);
      checkOutput();
      clockStep();

      // Both requesters continuously valid; the winner presents new data
      aR = 10; aD = $urandom; lR = 20; lD = $urandom;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0, 1, aR, aD, 1, lR, lD);
         checkOutput();
`ifdef WB_RR_ARB_EN
         expAlu = (k % 2 == 0);
`else
         expAlu = 1'b0;
`endif
         check("burst_alu_ready", alu_ready, expAlu);
         check("burst_lsu_ready", lsu_ready, !expAlu);
         clockStep();
         check("burst_addr", addr_rd, expAlu ? aR : lR);
         check("burst_data", data_rd, expAlu ? aD : lD);
         if (expAlu) begin aR++; aD = $urandom; end
         else        begin lR++; lD = $urandom; end
      end
      applyStimulus(0, 0, 0, 0, 1, aR, aD, 0, 0, 0);
      checkOutput();
      clockStep();

      // ---------------- x0 write and set/clear collision ----------------
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0);
      checkOutput();
      check("x0_alu_ready", alu_ready, 1);
      clockStep();
      check("x0_wr_en", wr_en, 0);
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      clockStep();
      applyStimulus(0, 0, 7, 0, 1, 7, 32'h77, 0, 0, 0);
      checkOutput();
      clockStep();
      check("coll_wr_en", wr_en, 1);
      applyStimulus(1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      clockStep();
      check("coll_sb_empty", sb_empty, 0);
      applyStimulus(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      check("coll_busy7", rs1_busy, 1);
      clockStep();
      applyStimulus(0, 0, 7, 0, 1, 7, 32'h78, 0, 0, 0);
      checkOutput();
      clockStep();
      idleStep(7);

      // ---------------- Back-to-back LSU writes ----------------
      for (int r = 1; r <= 3; r++) begin
         applyStimulus(1, AW'(r), 0, 0, 0, 0, 0, 0, 0, 0);
         checkOutput();
         clockStep();
      end
      for (int r = 1; r <= 3; r++) begin
         applyStimulus(0, 0, AW'(r), AW'(r % 3 + 1), 0, 0, 0, 1, AW'(r), 32'hA0 + r);
         checkOutput();
         clockStep();
         check("b2b_wr_en", wr_en, 1);
         check("b2b_addr", addr_rd, r);
         check("b2b_data", data_rd, 32'hA0 + r);
      end
      idleStep(3);
      check("b2b_sb_empty", sb_empty, 1);

      // ---------------- Randomized run ----------------
      aV = 1'b0; lV = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (!aV && $urandom_range(0, 99) < 60) begin
            aV = 1'b1; aR = AW'($urandom_range(0, 31)); aD = $urandom;
         end
         if (!lV && $urandom_range(0, 99) < 50) begin
            lV = 1'b1; lR = AW'($urandom_range(0, 31)); lD = $urandom;
         end
         applyStimulus($urandom_range(0, 99) < 40, AW'($urandom_range(0, 31)),
                       AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                       aV, aR, aD, lV, lR, lD);
         checkOutput();
         clockStep();
         if (expAluGnt) aV = 1'b0;
         if (expLsuGnt) lV = 1'b0;
      end

      // ---------------- Reset mid-operation ----------------
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      clockStep();
      applyStimulus(1, 10, 0, 0, 1, 12, 32'h1234, 0, 0, 0);
      checkOutput();
      clockStep();
      // A request is accepted here but reset arrives before its edge
      applyStimulus(0, 0, 9, 10, 1, 9, 32'h9999, 0, 0, 0);
      checkOutput();
      check("pre_reset_rs1", rs1_busy, 1);
      reset_n = 1'b0;
      #1;
      modelReset();
      check("midreset_wr_en", wr_en, 0);
      check("midreset_addr_rd", addr_rd, 0);
      check("midreset_data_rd", data_rd, 0);
      check("midreset_sb_empty", sb_empty, 1);
      check("midreset_rs1_busy", rs1_busy, 0);
      check("midreset_rs2_busy", rs2_busy, 0);
      applyStimulus(0, 0, 9, 10, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_wr_en", wr_en, 0);
      idleStep(9);
      check("post_reset_sb_empty", sb_empty, 1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
